// File: rtl/usb_adc_stream_ep.sv
// usb_adc_stream_ep
//
// Bulk-IN streaming endpoint that moves ADC samples into the USB device
// controller's endpoint TX interface. Samples are zero-extended to 16 bits
// and stored in a word buffer. They are sent LSB first. A packet is only
// committed (released from the buffer) once the host acknowledges it. An
// aborted IN therefore replays the same bytes on the next IN.
//
// Optional feature macro: ADC_STREAM_SEQ_HDR_EN
//   When defined, the first two bytes of each packet carry a 16-bit packet
//   sequence number, LSB first. The payload then shrinks to PKT_BYTES-2.
//
// Ports
//   clk_i        PHY clock; all logic on the rising edge
//   reset_i      synchronous active-high reset
//   stream_en_i  accept samples; low while idle flushes the buffer
//   adc_data_i   sample data (ADC_W bits)
//   adc_valid_i  one-cycle sample strobe
//   endpt_i      endpoint addressed by the controller
//   txact_i      IN transaction active
//   txpop_i      controller consumes one byte
//   txpktfin_i   packet acknowledged by host
//   txdat_o      current byte (registered, first-word-fall-through)
//   txval_o      txdat_o valid
//   txdat_len_o  packet length (constant PKT_BYTES)
//   txcork_o     high = NAK, not enough committed-side data for a packet
//   ovf_cnt_o    dropped-sample count, saturating
//   level_o      occupancy in words, measured from the commit pointer
module usb_adc_stream_ep #(
  parameter int ADC_W     = 10,
  parameter int FIFO_AW   = 10,
  parameter int PKT_BYTES = 512,
  parameter int EP_NUM    = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               stream_en_i,
  input  logic [ADC_W-1:0]   adc_data_i,
  input  logic               adc_valid_i,
  input  logic [3:0]         endpt_i,
  input  logic               txact_i,
  input  logic               txpop_i,
  input  logic               txpktfin_i,
  output logic [7:0]         txdat_o,
  output logic               txval_o,
  output logic [11:0]        txdat_len_o,
  output logic               txcork_o,
  output logic [15:0]        ovf_cnt_o,
  output logic [FIFO_AW:0]   level_o
);

`ifdef ADC_STREAM_SEQ_HDR_EN
  localparam int PKT_PAYLOAD = PKT_BYTES - 2;
`else
  localparam int PKT_PAYLOAD = PKT_BYTES;
`endif
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 2;   // byte pointer width

  localparam logic [PW-1:0]    PAYLOAD_B = PW'(PKT_PAYLOAD);
  localparam logic [PW-1:0]    PKT_B     = PW'(PKT_BYTES);
  localparam logic [FIFO_AW:0] FULL_W    = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_FIN} state_e;

  function automatic logic [15:0] zext(input logic [ADC_W-1:0] s);
    logic [15:0] w;
    w = '0;
    w[ADC_W-1:0] = s;
    return w;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0]      mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q;
  logic [PW-1:0]    rd_commit_q;
  logic [PW-1:0]    rd_spec_q;
  logic [PW-1:0]    cnt_q;        // bytes popped in the current packet
  state_e           state_q;
  logic [7:0]       txdat_q;
  logic             txval_q;
  logic             cork_q;
  logic [15:0]      ovf_q;
`ifdef ADC_STREAM_SEQ_HDR_EN
  logic [15:0]      seq_q;
`endif

  logic [FIFO_AW:0] used_w;
  logic [PW-1:0]    avail;
  logic             full;
  logic             wr_en;
  logic             ep_hit;
  logic             pop_ok;
  logic             flush;
  logic [PW-1:0]    cnt_d;
  logic [PW-1:0]    rd_spec_d;
  logic [7:0]       nxt_byte;
  logic [7:0]       first_byte;

  // Occupancy is always measured against the committed read pointer so
  // in-flight (unacknowledged) bytes can never be overwritten.
  assign used_w = wr_ptr_q - rd_commit_q[PW-1:1];
  assign avail  = {wr_ptr_q, 1'b0} - rd_commit_q;
  assign full   = (used_w == FULL_W);
  assign wr_en  = adc_valid_i && stream_en_i && !full;
  assign ep_hit = (endpt_i == 4'(EP_NUM));
  assign pop_ok = txpop_i && ep_hit;
  assign flush  = (state_q == S_IDLE) && !stream_en_i && !txact_i;

  // Byte presented after the next pop, and the first byte of a packet.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
`ifdef ADC_STREAM_SEQ_HDR_EN
    rd_spec_d  = (cnt_q >= PW'(2)) ? rd_spec_q + 1'b1 : rd_spec_q;
    nxt_byte   = pick_byte(mem_q[rd_spec_d[FIFO_AW:1]], rd_spec_d[0]);
    if (cnt_q == '0) nxt_byte = seq_q[15:8];
    first_byte = seq_q[7:0];
`else
    rd_spec_d  = rd_spec_q + 1'b1;
    nxt_byte   = pick_byte(mem_q[rd_spec_d[FIFO_AW:1]], rd_spec_d[0]);
    first_byte = pick_byte(mem_q[rd_commit_q[FIFO_AW:1]], rd_commit_q[0]);
`endif
  end

  // Sample storage (data only, no reset)
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= zext(adc_data_i);
  end

  // Pointers, accounting and packet FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_commit_q <= '0;
      rd_spec_q   <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      txdat_q     <= '0;
      txval_q     <= 1'b0;
      cork_q      <= 1'b1;
      ovf_q       <= '0;
`ifdef ADC_STREAM_SEQ_HDR_EN
      seq_q       <= '0;
`endif
    end else begin
      if (flush)      wr_ptr_q <= '0;
      else if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;

      // Full is judged before any commit landing this same cycle.
      if (adc_valid_i && stream_en_i && full) ovf_q <= sat_inc(ovf_q);

      // Cork tracks avail only while idle; it stays frozen during a packet.
      if (state_q == S_IDLE) cork_q <= (avail < PAYLOAD_B);

      case (state_q)
        S_IDLE: begin
          if (flush) begin
            rd_commit_q <= '0;
            rd_spec_q   <= '0;
`ifdef ADC_STREAM_SEQ_HDR_EN
            seq_q       <= '0;
`endif
          end else if (txact_i && ep_hit && !cork_q) begin
            state_q   <= S_SEND;
            rd_spec_q <= rd_commit_q;
            cnt_q     <= '0;
            txdat_q   <= first_byte;
            txval_q   <= 1'b1;
          end
        end
        S_SEND: begin
          if (!txact_i) begin
            state_q   <= S_IDLE;
            rd_spec_q <= rd_commit_q;
            txval_q   <= 1'b0;
          end else if (pop_ok) begin
            cnt_q     <= cnt_d;
            rd_spec_q <= rd_spec_d;
            txdat_q   <= nxt_byte;
            if (cnt_d == PKT_B) begin
              state_q <= S_WAIT_FIN;
              txval_q <= 1'b0;
            end
          end
        end
        S_WAIT_FIN: begin
          if (txpktfin_i) begin
            state_q     <= S_IDLE;
            rd_commit_q <= rd_spec_q;
`ifdef ADC_STREAM_SEQ_HDR_EN
            seq_q       <= seq_q + 16'd1;
`endif
          end else if (!txact_i) begin
            state_q   <= S_IDLE;
            rd_spec_q <= rd_commit_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign txdat_o     = txdat_q;
  assign txval_o     = txval_q;
  assign txcork_o    = cork_q;
  assign txdat_len_o = 12'(PKT_BYTES);
  assign ovf_cnt_o   = ovf_q;
  assign level_o     = used_w;

endmodule

// File: tb/tb_usb_adc_stream_ep.sv
// Testbench for usb_adc_stream_ep: a sample-queue reference model produces the
// expected packet bytes, which a negedge monitor compares against txdat_o.
module tb_usb_adc_stream_ep;

  localparam int ADC_W   = 10;
  localparam int FIFO_AW = 8;
  localparam int PKT     = 512;
  localparam logic [3:0] EP = 4'd2;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int ADC_MAX = (1 << ADC_W) - 1;
`ifdef ADC_STREAM_SEQ_HDR_EN
  localparam int PAY = PKT - 2;
`else
  localparam int PAY = PKT;
`endif
  localparam int N_THR = (PAY + 1) / 2;   // words needed to uncork

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             stream_en_i = 1'b0;
  logic [ADC_W-1:0] adc_data_i = '0;
  logic             adc_valid_i = 1'b0;
  logic [3:0]       endpt_i = EP;
  logic             txact_i = 1'b0;
  logic             txpop_i = 1'b0;
  logic             txpktfin_i = 1'b0;
  logic [7:0]       txdat_o;
  logic             txval_o;
  logic [11:0]      txdat_len_o;
  logic             txcork_o;
  logic [15:0]      ovf_cnt_o;
  logic [FIFO_AW:0] level_o;

  usb_adc_stream_ep #(.ADC_W(ADC_W), .FIFO_AW(FIFO_AW), .PKT_BYTES(PKT), .EP_NUM(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .stream_en_i(stream_en_i),
    .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i), .endpt_i(endpt_i),
    .txact_i(txact_i), .txpop_i(txpop_i), .txpktfin_i(txpktfin_i),
    .txdat_o(txdat_o), .txval_o(txval_o), .txdat_len_o(txdat_len_o),
    .txcork_o(txcork_o), .ovf_cnt_o(ovf_cnt_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: samples not yet acknowledged, in arrival order.
  int unsigned mq[$];
  int unsigned m_ovf = 0;
  int unsigned m_seq = 0;
  int unsigned pkt_q[$];
  int unsigned exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void m_write(input int unsigned v);
    if (mq.size() < DEPTH) mq.push_back(v & ADC_MAX);
    else if (m_ovf < 65535) m_ovf++;
  endfunction

  function automatic void m_commit();
    for (int k = 0; k < PAY / 2; k++) void'(mq.pop_front());
    m_seq = (m_seq + 1) & 16'hFFFF;
  endfunction

  function automatic void build_pkt();
    pkt_q.delete();
`ifdef ADC_STREAM_SEQ_HDR_EN
    pkt_q.push_back(m_seq & 8'hFF);
    pkt_q.push_back((m_seq >> 8) & 8'hFF);
`endif
    for (int k = 0; k < PAY / 2; k++) begin
      pkt_q.push_back(mq[k] & 8'hFF);
      pkt_q.push_back((mq[k] >> 8) & 8'hFF);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int unsigned v);
    adc_data_i  = v[ADC_W-1:0];
    adc_valid_i = 1'b1;
    m_write(v);
    tick();
    adc_valid_i = 1'b0;
  endtask

  // Monitor: every byte the bench pops from our endpoint is scored.
  always @(negedge clk) begin
    if (!reset_i && txpop_i && endpt_i == EP) begin
      if (!txval_o) chk("txval_at_pop", int'(txval_o), 1);
      else if (exp_q.size() == 0) chk("unexpected_byte", int'(txdat_o), -1);
      else chk("txdat", int'(txdat_o), int'(exp_q.pop_front()));
    end
  end

  // One IN transaction. mode 0: full packet then ack; mode 1: drop txact.
  task automatic do_in(input int npops, input int mode, input bit noise, input bit fin_wr);
    int popped;
    int r;
    build_pkt();
    for (int i = 0; i < npops; i++) exp_q.push_back(pkt_q[i]);
    endpt_i = EP;
    txact_i = 1'b1;
    tick();
    chk("txval_on_entry", int'(txval_o), 1);
    popped = 0;
    while (popped < npops) begin
      r = noise ? int'($urandom_range(0, 7)) : 7;
      endpt_i = EP;
      txpop_i = 1'b1;
      if (r == 0) txpop_i = 1'b0;
      else if (r == 1) endpt_i = EP + 4'd1;   // pop aimed at another endpoint
      else popped++;
      if (noise && $urandom_range(0, 3) == 0) begin
        adc_data_i  = ADC_W'($urandom_range(0, ADC_MAX));
        adc_valid_i = 1'b1;
        m_write(adc_data_i);
      end
      tick();
      adc_valid_i = 1'b0;
    end
    txpop_i = 1'b0;
    endpt_i = EP;
    if (npops == PKT) chk("txval_after_last", int'(txval_o), 0);
    if (mode == 0) begin
      txpktfin_i = 1'b1;
      if (fin_wr) begin
        adc_data_i  = ADC_W'($urandom_range(0, ADC_MAX));
        adc_valid_i = 1'b1;
        m_write(adc_data_i);
      end
      m_commit();
      tick();
      txpktfin_i  = 1'b0;
      adc_valid_i = 1'b0;
      txact_i     = 1'b0;
    end else begin
      txact_i = 1'b0;
      tick();
    end
    chk("level_after_in", int'(level_o), mq.size());
    chk("ovf_after_in", int'(ovf_cnt_o), int'(m_ovf));
  endtask

  initial begin
    repeat (3) tick();
    reset_i     = 1'b0;
    stream_en_i = 1'b1;
    chk("rst_txdat", int'(txdat_o), 0);
    chk("rst_txval", int'(txval_o), 0);
    chk("rst_cork", int'(txcork_o), 1);
    chk("rst_len", int'(txdat_len_o), PKT);
    chk("rst_ovf", int'(ovf_cnt_o), 0);
    chk("rst_level", int'(level_o), 0);

    // Cork threshold, data 0x000.. ascending
    for (int i = 0; i < N_THR - 1; i++) put(i);
    tick(); tick();
    chk("cork_below_thr", int'(txcork_o), 1);
    chk("level_below_thr", int'(level_o), N_THR - 1);
    put(N_THR - 1);
    chk("cork_lag1", int'(txcork_o), 1);
    tick();
    chk("cork_lag2", int'(txcork_o), 0);
    for (int i = N_THR; i < 256; i++) put(i);
    tick(); tick();
    chk("level_256", int'(level_o), 256);

    // Aborted IN then full retransmission with ack
    do_in(100, 1, 1'b0, 1'b0);
    tick(); tick();
    do_in(PKT, 0, 1'b0, 1'b0);
    tick(); tick();

    // Fill to full plus four dropped samples
    begin
      int n;
      n = DEPTH + 4 - mq.size();
      for (int i = 0; i < n; i++) put($urandom_range(0, ADC_MAX));
    end
    tick(); tick();
    chk("level_full", int'(level_o), DEPTH);
    chk("ovf_4", int'(ovf_cnt_o), 4);

    // Ack coincides with a sample while full: dropped, commit still applied
    do_in(PKT, 0, 1'b0, 1'b1);
    chk("ovf_5", int'(ovf_cnt_o), 5);
    tick(); tick();

    // Not enough data: IN must be NAKed
    chk("cork_low_data", int'(txcork_o), (mq.size() * 2 < PAY) ? 1 : 0);
    txact_i = 1'b1;
    tick();
    chk("nak_txval", int'(txval_o), 0);
    txact_i = 1'b0;
    tick();

    // Flush keeps the overflow count
    stream_en_i = 1'b0;
    tick();
    stream_en_i = 1'b1;
    mq.delete();
    m_seq = 0;
    chk("flush_level", int'(level_o), 0);
    chk("flush_ovf", int'(ovf_cnt_o), int'(m_ovf));

    // Randomized traffic with aborts, gaps, foreign pops and concurrent writes
    for (int it = 0; it < 12; it++) begin
      int nw;
      nw = $urandom_range(0, 300);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 3) != 0) put($urandom_range(0, ADC_MAX));
        else tick();
      end
      tick(); tick();
      chk("rnd_level", int'(level_o), mq.size());
      chk("rnd_ovf", int'(ovf_cnt_o), int'(m_ovf));
      chk("rnd_cork", int'(txcork_o), (mq.size() * 2 < PAY) ? 1 : 0);
      if (mq.size() * 2 >= PAY) begin
        if ($urandom_range(0, 2) == 0) begin
          do_in($urandom_range(1, PKT), 1, 1'b1, 1'b0);
          tick(); tick();
        end
        do_in(PKT, 0, 1'b1, 1'b0);
      end else begin
        txact_i = 1'b1;
        tick();
        chk("rnd_nak", int'(txval_o), 0);
        txact_i = 1'b0;
        tick();
      end
    end

    // Reset in the middle of a packet
    while (mq.size() * 2 < PAY) put($urandom_range(0, ADC_MAX));
    tick(); tick();
    build_pkt();
    for (int i = 0; i < 10; i++) exp_q.push_back(pkt_q[i]);
    txact_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      txpop_i = 1'b1;
      tick();
    end
    txpop_i = 1'b0;
    txact_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    mq.delete();
    m_ovf = 0;
    m_seq = 0;
    chk("mid_rst_txval", int'(txval_o), 0);
    chk("mid_rst_txdat", int'(txdat_o), 0);
    chk("mid_rst_cork", int'(txcork_o), 1);
    chk("mid_rst_level", int'(level_o), 0);
    chk("mid_rst_ovf", int'(ovf_cnt_o), 0);
    tick(); tick();
    chk("post_rst_cork", int'(txcork_o), 1);
    chk("bytes_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_adc_stream_ep.md
# usb_adc_stream_ep

Parametrised USB bulk-IN streaming endpoint that carries ADC samples from the parallel ADC input to the host through the USB device controller's endpoint TX interface. It is the successor to the fixed loopback endpoint: it generalises sample width, buffer depth, packet size and endpoint number. It adds packet-level retransmission and overflow accounting. It sits between the ADC capture logic and `USB_Device_Controller_Top`, clocked by the 60 MHz PHY clock.

## Interface

Parameters:
- ADC_W, 10, ADC sample width in bits, 1..16
- FIFO_AW, 10, log2 of sample buffer depth in 16-bit words
- PKT_BYTES, 512, bulk packet length in bytes; even; at most 2^(FIFO_AW+1)
- EP_NUM, 2, endpoint number served

Ports:
- clk_i  in  1  PHY clock; all logic on its rising edge
- reset_i  in  1  synchronous, active-high reset
- stream_en_i  in  1  accept samples when high
- adc_data_i  in  ADC_W  sample data
- adc_valid_i  in  1  one-cycle sample strobe, synchronous to clk_i
- endpt_i  in  4  endpoint currently addressed by the controller
- txact_i  in  1  controller IN transaction active
- txpop_i  in  1  controller consumes one byte
- txpktfin_i  in  1  packet acknowledged by host
- txdat_o  out  8  current byte to send
- txval_o  out  1  txdat_o valid
- txdat_len_o  out  12  packet length, constant PKT_BYTES
- txcork_o  out  1  high means NAK (not enough data)
- ovf_cnt_o  out  16  dropped-sample count, saturating
- level_o  out  FIFO_AW+1  committed occupancy in words

## Operation

- Storage: 2^FIFO_AW x 16-bit words. Each sample is zero-extended to 16 bits and sent as 2 bytes, LSB first.
- Pointers:
  - wr_ptr: word pointer, FIFO_AW+1 bits.
  - rd_commit and rd_spec: byte pointers, FIFO_AW+2 bits. Byte LSB selects the low or high half of the word.
  - All pointers wrap modulo their width.
- Write rules:
  - A sample is written when adc_valid_i and stream_en_i are high and the buffer is not full; wr_ptr then advances by 1.
  - Full means words between wr_ptr and rd_commit equal 2^FIFO_AW. Uncommitted (in-flight) data is never overwritten.
  - A sample arriving while full is dropped, and ovf_cnt_o increments, saturating at 16'hFFFF.
- Cork: avail = 2*wr_ptr - rd_commit, in bytes. txcork_o = (avail < PKT_PAYLOAD). Short packets are never sent.
- States: IDLE, SEND, WAIT_FIN.
  - IDLE -> SEND: txact_i high and endpt_i == EP_NUM and txcork_o low. rd_spec is loaded from rd_commit.
  - SEND: each txpop_i advances rd_spec by 1. When PKT_BYTES bytes have been popped, go to WAIT_FIN.
  - WAIT_FIN -> IDLE on txpktfin_i: rd_commit <= rd_spec.
  - SEND or WAIT_FIN -> IDLE if txact_i falls without txpktfin_i: rd_spec <= rd_commit. The packet is retransmitted whole on the next IN.
- Flush: stream_en_i low in IDLE with txact_i low sets wr_ptr, rd_commit and rd_spec to 0. ovf_cnt_o is kept.
- Simultaneous events:
  - A write and a txpktfin_i commit in the same cycle are both applied.
  - Full is evaluated against rd_commit before that cycle's commit.
- txpop_i while endpt_i != EP_NUM is ignored.

## Timing

- Reset values: txdat_o 0, txval_o 0, txcork_o 1, txdat_len_o PKT_BYTES, ovf_cnt_o 0, level_o 0, state IDLE, all pointers 0.
- Write latency: a sample is counted in level_o and avail on the cycle after adc_valid_i.
- txdat_o behaves as a registered first-word-fall-through output:
  - It is valid (txval_o high) from the cycle after entry to SEND.
  - It updates on the cycle after each txpop_i.
  - Back-to-back txpop_i is supported at one byte per cycle.
- txcork_o is registered and reflects avail one cycle late. While state != IDLE it is held at its value from the transition into SEND.
- Commit takes effect in the cycle after txpktfin_i. level_o updates on the same cycle.
- Reset mid-transfer returns everything to reset values; there is no partial commit.

## Configuration

- ADC_STREAM_SEQ_HDR_EN:
  - Defined: bytes 0 and 1 of every packet carry a 16-bit packet sequence number, LSB first. The payload is PKT_PAYLOAD = PKT_BYTES-2, and rd_spec advances only on payload pops.
  - The sequence increments on txpktfin_i, holds across retransmission, and resets to 0 on reset and flush.
  - Undefined: PKT_PAYLOAD = PKT_BYTES and no header is inserted.

## Test plan

- Reset, then 255 samples with PKT_BYTES=512 -> txcork_o stays 1. Sample 256 -> txcork_o goes 0 two cycles later.
- Samples 0x000..0x0FF with ADC_W=10, one IN with 512 pops and txpktfin_i -> bytes 00 00 01 00 … FF 00; level_o 256 -> 0.
- Same IN with txact_i dropped after 100 pops, then a full IN -> the second packet restarts at byte 00 00 and is identical to the full 512-byte stream.
- FIFO_AW=4, 20 samples with no IN -> level_o = 16, ovf_cnt_o = 4.
- With the macro defined, three acknowledged packets -> headers 00 00, 01 00, 02 00. A NAKed retry repeats the same header.
- 512 bytes popped, txpktfin_i asserted on the same cycle as adc_valid_i with the FIFO full -> the sample is dropped (ovf_cnt_o +1) and the commit is applied.
